// File: rtl/fifo_rd_stream_if.sv
// Bus bundle between the FIFO read port, this adapter and the stream consumer.
// The master modport is the adapter; the slave modport is the surrounding
// environment (FIFO plus consumer).
//
// Handshakes:
//   FIFO side  : fifo_rd_en high in a cycle with fifo_empty low is an accepted
//                read; fifo_data_out carries that word in the following cycle.
//   Stream side: a word transfers in every cycle where m_valid and m_ready are
//                both high. Once m_valid is high, m_valid and m_data stay
//                unchanged until the transfer happens. m_valid never waits on
//                m_ready.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] fifo_data_out;
    logic                  fifo_empty;
    logic                  fifo_underflow;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        input  fifo_data_out,
        input  fifo_empty,
        input  fifo_underflow,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid
    );

    modport slave (
        output fifo_data_out,
        output fifo_empty,
        output fifo_underflow,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns a one-cycle-latency FIFO read port into a valid/ready
// stream. A 2-entry in-order buffer absorbs the word still in flight when the
// consumer stalls, so reads can be issued back to back at full rate.
//
// Optional feature: define FIFO_RD_STREAM_STATS_EN to build the word and stall
// counters; otherwise word_cnt and stall_cnt are tied to zero.
//
// dbg_buf_cnt / dbg_inflight expose the internal occupancy state.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_rd_stream_if.master    bus,
    output logic                proto_err,
    output logic [31:0]         word_cnt,
    output logic [31:0]         stall_cnt,
    output logic [1:0]          dbg_buf_cnt,
    output logic                dbg_inflight
);

    // Occupancy and pointers of the 2-entry buffer.
    logic [1:0]            buf_cnt;
    logic                  head;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] buf_mem [2];

    // Set on the first edge after reset release; keeps reads off until then.
    logic                  run;

    // The read that produced the current in-flight word was issued while empty.
    logic                  rd_from_empty;

    logic                  pop;
    logic [2:0]            avail;
    logic                  rd_en;
    logic                  wr_slot;
    logic                  valid;

    // Read request: issue whenever the buffer can still hold everything already
    // committed after this cycle's pop (includes the m_ready path).
    always_comb begin
        valid   = (buf_cnt != 2'd0);
        pop     = valid && bus.m_ready;
        avail   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
        rd_en   = run && !bus.fifo_empty && (avail < 3'd2);
        // Tail slot is head + buf_cnt (mod 2). buf_cnt=2 never coincides with
        // a capture because buf_cnt + inflight never exceeds 2.
        wr_slot = head ^ buf_cnt[0];
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid;
    // Head slot is only presented while valid, so m_data reads 0 when idle.
    assign bus.m_data     = valid ? buf_mem[head] : '0;

    assign dbg_buf_cnt  = buf_cnt;
    assign dbg_inflight = inflight;

    // Control state: occupancy, head pointer, in-flight tracking, sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run           <= 1'b0;
            inflight      <= 1'b0;
            rd_from_empty <= 1'b0;
            buf_cnt       <= 2'd0;
            head          <= 1'b0;
            proto_err     <= 1'b0;
        end else begin
            run           <= 1'b1;
            inflight      <= rd_en;
            rd_from_empty <= rd_en && bus.fifo_empty;
            buf_cnt       <= buf_cnt + {1'b0, inflight} - {1'b0, pop};
            if (pop) begin
                head <= ~head;
            end
            if (bus.fifo_underflow || (inflight && rd_from_empty)) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Data capture: the word read last cycle lands in the tail slot.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_mem[wr_slot] <= bus.fifo_data_out;
        end
    end

`ifdef FIFO_RD_STREAM_STATS_EN
    // Statistics: delivered words and backpressure cycles, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (pop) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (valid && !bus.m_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`else
    assign word_cnt  = 32'd0;
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an 8-deep behavioural FIFO feeds the DUT; every
// word written is pushed to exp_q and checked in order when the stream pops it.
module tb_fifo_rd_stream;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(W)) bus ();

    logic        proto_err;
    logic [31:0] word_cnt;
    logic [31:0] stall_cnt;
    logic [1:0]  dbg_buf_cnt;
    logic        dbg_inflight;

    fifo_rd_stream #(.DATA_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .proto_err    (proto_err),
        .word_cnt     (word_cnt),
        .stall_cnt    (stall_cnt),
        .dbg_buf_cnt  (dbg_buf_cnt),
        .dbg_inflight (dbg_inflight)
    );

    // ---------------- FIFO model (8 deep, 1-cycle read latency) ----------------
    logic [W-1:0] f_mem [8];
    logic [2:0]   f_wr_ptr, f_rd_ptr;
    logic [3:0]   f_cnt;
    logic [W-1:0] f_dout;
    logic         f_uf;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         force_uf;
    logic         f_rd_ok, f_wr_ok;

    assign f_rd_ok = bus.fifo_rd_en && (f_cnt != 4'd0);
    assign f_wr_ok = wr_en && ((f_cnt != 4'd8) || f_rd_ok);
    assign bus.fifo_empty     = (f_cnt == 4'd0);
    assign bus.fifo_data_out  = f_dout;
    assign bus.fifo_underflow = f_uf | force_uf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wr_ptr <= 3'd0;
            f_rd_ptr <= 3'd0;
            f_cnt    <= 4'd0;
            f_dout   <= '0;
            f_uf     <= 1'b0;
        end else begin
            if (f_rd_ok) begin
                f_dout   <= f_mem[f_rd_ptr];
                f_rd_ptr <= f_rd_ptr + 3'd1;
            end
            if (f_wr_ok) f_wr_ptr <= f_wr_ptr + 3'd1;
            f_uf  <= bus.fifo_rd_en && (f_cnt == 4'd0);
            f_cnt <= f_cnt + {3'b000, f_wr_ok} - {3'b000, f_rd_ok};
        end
    end

    always @(posedge clk) begin
        if (rst_n && f_wr_ok) f_mem[f_wr_ptr] <= wr_data;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_w;
    int checks   = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (rst_n && bus.m_valid && bus.m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_extra_pop: got m_data=%h, required no pop (nothing outstanding)", bus.m_data);
            end else begin
                exp_w = exp_q.pop_front();
                if (bus.m_data !== exp_w) begin
                    failures++;
                    $display("FAIL sb_data: got m_data=%h, required %h", bus.m_data, exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic en, input logic [W-1:0] d, input logic rdy);
        @(posedge clk);
        #1;
        wr_en       = en;
        wr_data     = d;
        bus.m_ready = rdy;
        if (en) exp_q.push_back(d);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        force_uf    = 1'b0;
        bus.m_ready = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL rst_rd_en: got %b required 0", bus.fifo_rd_en); end
        checks++; if (bus.m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid: got %b required 0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin failures++; $display("FAIL rst_m_data: got %h required 0", bus.m_data); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto_err: got %b required 0", proto_err); end
        checks++; if (word_cnt !== 32'd0) begin failures++; $display("FAIL rst_word_cnt: got %0d required 0", word_cnt); end
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall_cnt: got %0d required 0", stall_cnt); end
        checks++; if (dbg_buf_cnt !== 2'd0 || dbg_inflight !== 1'b0) begin failures++; $display("FAIL rst_state: got buf_cnt=%0d inflight=%b required 0/0", dbg_buf_cnt, dbg_inflight); end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        int first_rd = -1;
        int first_v  = -1;
        int last_v   = -1;
        int nvalid   = 0;
        for (int i = 0; i < 16; i++) begin
            drive(i < 8, W'(32'h0001 + i), 1'b1);
            @(negedge clk);
            if (bus.fifo_rd_en && first_rd < 0) first_rd = i;
            if (bus.m_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                nvalid++;
            end
        end
        checks++; if (first_rd < 0 || first_v - first_rd != 2) begin failures++; $display("FAIL stream_latency: got %0d cycles required 2", first_v - first_rd); end
        checks++; if (nvalid != 8 || last_v - first_v != 7) begin failures++; $display("FAIL stream_rate: got %0d valid over %0d cycles required 8 over 8", nvalid, last_v - first_v + 1); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_drain: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int c0 = -1;
        int hold_bad = 0;
        logic [31:0] base = 32'd0;
        logic [31:0] exp_stall;
        for (int i = 0; i < 40; i++) begin
            drive(i < 4, W'(32'h1001 + i), 1'b0);
            @(negedge clk);
            if (bus.m_valid && c0 < 0) begin
                c0 = i;
                base = stall_cnt;
            end
            if (c0 >= 0 && (bus.m_valid !== 1'b1 || bus.m_data !== 16'h1001)) hold_bad++;
            if (c0 >= 0 && i == c0 + 9) begin
                checks++; if (dbg_buf_cnt !== 2'd2) begin failures++; $display("FAIL bp_buf_cnt: got %0d required 2", dbg_buf_cnt); end
                checks++; if (bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL bp_rd_en: got %b required 0", bus.fifo_rd_en); end
                checks++; if (bus.m_data !== 16'h1001) begin failures++; $display("FAIL bp_head: got %h required 1001", bus.m_data); end
                break;
            end
        end
        checks++; if (c0 < 0 || hold_bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles (first valid at %0d) required 0", hold_bad, c0); end
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
`ifdef FIFO_RD_STREAM_STATS_EN
        exp_stall = base + 32'd10;
`else
        exp_stall = 32'd0;
`endif
        checks++; if (stall_cnt !== exp_stall) begin failures++; $display("FAIL bp_stall_cnt: got %0d required %0d", stall_cnt, exp_stall); end
        for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.m_valid); i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain: got %0d outstanding required 0", exp_q.size()); end
    endtask

    task automatic test_empty();
        int bad_rd = 0, bad_v = 0, bad_pe = 0, bad_uf = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            if (bus.fifo_rd_en !== 1'b0) bad_rd++;
            if (bus.m_valid !== 1'b0) bad_v++;
            if (proto_err !== 1'b0) bad_pe++;
            if (bus.fifo_underflow !== 1'b0) bad_uf++;
        end
        checks++; if (bad_rd != 0) begin failures++; $display("FAIL empty_rd_en: got %0d cycles high required 0", bad_rd); end
        checks++; if (bad_v != 0) begin failures++; $display("FAIL empty_m_valid: got %0d cycles high required 0", bad_v); end
        checks++; if (bad_pe != 0) begin failures++; $display("FAIL empty_proto_err: got %0d cycles high required 0", bad_pe); end
        checks++; if (bad_uf != 0) begin failures++; $display("FAIL empty_underflow: got %0d cycles high required 0", bad_uf); end
    endtask

    task automatic test_underflow();
        int low = 0;
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL uf_before: got %b required 0", proto_err); end
        @(posedge clk); #1; force_uf = 1'b1;
        @(posedge clk); #1; force_uf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (proto_err !== 1'b1) low++;
        end
        checks++; if (low != 0) begin failures++; $display("FAIL uf_sticky: got %0d cycles low required 0", low); end
    endtask

    task automatic test_mid_reset();
        int found = 0;
        int n;
        apply_reset();
        @(negedge clk);
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL mr_err_cleared: got %b required 0", proto_err); end
        for (int i = 0; i < 20; i++) begin
            drive(i < 4, W'(32'h3001 + i), 1'b0);
            @(negedge clk);
            if (dbg_buf_cnt == 2'd1 && dbg_inflight == 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++; if (found != 1) begin failures++; $display("FAIL mr_setup: got buf_cnt=%0d inflight=%b required 1/1", dbg_buf_cnt, dbg_inflight); end
        rst_n = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        #1;
        checks++; if (bus.m_valid !== 1'b0 || bus.m_data !== '0 || bus.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL mr_outputs: got valid=%b data=%h rd_en=%b required 0/0/0", bus.m_valid, bus.m_data, bus.fifo_rd_en); end
        checks++; if (dbg_buf_cnt !== 2'd0 || dbg_inflight !== 1'b0 || word_cnt !== 32'd0 || stall_cnt !== 32'd0) begin failures++; $display("FAIL mr_state: got buf_cnt=%0d inflight=%b word=%0d stall=%0d required all 0", dbg_buf_cnt, dbg_inflight, word_cnt, stall_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'hA5A5, 1'b1);
        for (n = 0; n < 10; n++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            if (bus.m_valid) break;
        end
        checks++; if (bus.m_valid !== 1'b1 || bus.m_data !== 16'hA5A5) begin failures++; $display("FAIL mr_first_word: got valid=%b data=%h required 1/a5a5", bus.m_valid, bus.m_data); end
        drive(1'b0, '0, 1'b1);
    endtask

    task automatic test_toggle();
        int pops = 0;
        logic [31:0] exp_words;
        apply_reset();
        for (int k = 0; k < 8; k++) drive(1'b1, W'(32'h2000 + k * 7), 1'b0);
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, '0, (i % 2) == 0);
            @(negedge clk);
            if (bus.m_valid && bus.m_ready) pops++;
        end
`ifdef FIFO_RD_STREAM_STATS_EN
        exp_words = 32'd8;
`else
        exp_words = 32'd0;
`endif
        checks++; if (pops != 8) begin failures++; $display("FAIL tog_pops: got %0d required 8", pops); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL tog_drain: got %0d outstanding required 0", exp_q.size()); end
        checks++; if (word_cnt !== exp_words) begin failures++; $display("FAIL tog_word_cnt: got %0d required %0d", word_cnt, exp_words); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = '0;
        force_uf    = 1'b0;
        bus.m_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty();
        test_underflow();
        test_mid_reset();
        test_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: got no completion by 100000 ns required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
